fetch_dec_buf: RTL and testbench
================================

Name: fetch_dec_buf

Overview:
- Pipeline register between the Fetch and Decode stages of the core.
- Captures the fetched PC and instruction word on the rising clock edge when enabled, and presents them to Decode for one or more cycles.
- Holds its contents while `enable` is low, to stall Decode.
- Resets to a known empty/NOP state.

Parameters:
- PC_W, 32, width of the program-counter field.
- INSTR_W, 32, width of the instruction field.
- RST_PC, 0, value loaded into o_pc on reset (and on flush when enabled).
- RST_INSTR, 0, value loaded into o_instruction on reset (and on flush); 0 is treated as NOP by Decode.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; 0 = in reset.
- enable  input  1  load enable; 1 = capture inputs at the next rising edge, 0 = hold.
- i_pc  input  PC_W  PC of the instruction fetched this cycle.
- i_instruction  input  INSTR_W  instruction word fetched this cycle.
- o_pc  output  PC_W  registered PC presented to Decode.
- o_instruction  output  INSTR_W  registered instruction presented to Decode.
- (FETCH_DEC_BUF_FLUSH_EN only) i_flush  input  1  synchronous squash request.
- (FETCH_DEC_BUF_FLUSH_EN only) o_valid  output  1  1 = registered contents are a real instruction.

Behaviour:
- Clock and reset: one clock domain (clk). rst is asynchronous and active-low.
- Reset:
  - While rst=0, o_pc=RST_PC and o_instruction=RST_INSTR immediately, independent of clk, and held.
  - Deassertion (0→1) takes effect at the next rising clk edge; no capture occurs on the edge where rst is still low.
- Capture: at rising clk with rst=1 and enable=1, o_pc<=i_pc and o_instruction<=i_instruction. Latency is exactly one clock; outputs change only after the edge.
- Hold: at rising clk with rst=1 and enable=0, both outputs keep their previous values. Input changes while holding have no effect.
- Registers only: no combinational path from any input to any output, except the asynchronous rst path.
- Input changes between clock edges never appear on the outputs until the next enabled edge.
- Enable toggling between edges is irrelevant; only its value at the rising edge matters.
- Both fields always update together; a partial update is not allowed.
- Widths pass straight through: no sign extension, no arithmetic.
- Reset mid-operation: asserting rst at any time clears both outputs at once, overriding enable and any capture in flight.
- X on enable while rst=0 has no effect; outputs stay at reset values.

Optional Feature:
- Macro: FETCH_DEC_BUF_FLUSH_EN.
- Defined:
  - Adds i_flush and o_valid.
  - At rising clk with i_flush=1, load o_pc=RST_PC, o_instruction=RST_INSTR, o_valid=0. Flush takes priority over enable=0 (flush works even while stalled).
  - At an enabled edge without flush, o_valid<=1. On a hold, o_valid holds.
  - Reset forces o_valid=0.
- Undefined: no extra ports, no valid logic; behaviour exactly as above.

Test Plan:
- Reset: rst=0 with i_pc=5, i_instruction=10, enable=1, clock running → o_pc=0, o_instruction=0 on every edge. Assert rst asynchronously mid-cycle after outputs=99/199 → outputs go to 0 before the next edge.
- Capture: rst=1, enable=1, i_pc=5, i_instruction=10 → after the next rising edge o_pc=5, o_instruction=10. Change to 20/30 mid-cycle → outputs stay 5/10 until the following edge, then 20/30.
- Stall: captured 5/10, then enable=0 with i_pc=55, i_instruction=67, then 7/9 over several edges → outputs stay 5/10 throughout.
- Resume: after the stall, enable=1 with i_pc=99, i_instruction=199 → exactly one edge later outputs are 99/199.
- Back-to-back: enable=1, inputs 1/11, 2/22, 3/33 on consecutive cycles → outputs follow each value with one-cycle latency, no drops or duplicates.
- Flush (macro defined): contents 99/199 with o_valid=1, then i_flush=1 and enable=0 → after the edge outputs are 0/0 and o_valid=0. Next enabled edge with 7/9 → outputs 7/9, o_valid=1.

Source files
------------

// File: rtl/fetch_dec_buf.sv
// rtl/fetch_dec_buf.sv - Fetch-to-Decode pipeline register with load enable (stall)
//
// Purpose:
//   Registers the fetched PC and instruction word for the Decode stage.
//   enable=1 captures at the rising edge, enable=0 holds the current contents.
//   rst (asynchronous, active-low) forces both fields to RST_PC / RST_INSTR.
//
// Ports:
//   clk            in   system clock, rising-edge active
//   rst            in   asynchronous active-low reset
//   enable         in   1 = capture i_pc/i_instruction at next edge, 0 = hold
//   i_pc           in   [PC_W-1:0]    PC fetched this cycle
//   i_instruction  in   [INSTR_W-1:0] instruction word fetched this cycle
//   o_pc           out  [PC_W-1:0]    registered PC to Decode
//   o_instruction  out  [INSTR_W-1:0] registered instruction to Decode
//   i_flush        in   (FETCH_DEC_BUF_FLUSH_EN) synchronous squash, beats enable=0
//   o_valid        out  (FETCH_DEC_BUF_FLUSH_EN) 1 = contents are a real instruction
//
// Optional feature macro: FETCH_DEC_BUF_FLUSH_EN

module fetch_dec_buf #(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [PC_W-1:0]    RST_PC    = '0,
    parameter logic [INSTR_W-1:0] RST_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [PC_W-1:0]    i_pc,
    input  logic [INSTR_W-1:0] i_instruction,
`ifdef FETCH_DEC_BUF_FLUSH_EN
    input  logic               i_flush,
    output logic               o_valid,
`endif
    output logic [PC_W-1:0]    o_pc,
    output logic [INSTR_W-1:0] o_instruction
);

`ifdef FETCH_DEC_BUF_FLUSH_EN
    // Flush is checked before enable so a stalled stage can still be squashed.
    // Both fields and the valid bit move together in every branch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_pc          <= RST_PC;
            o_instruction <= RST_INSTR;
            o_valid       <= 1'b0;
        end else if (i_flush) begin
            o_pc          <= RST_PC;
            o_instruction <= RST_INSTR;
            o_valid       <= 1'b0;
        end else if (enable) begin
            o_pc          <= i_pc;
            o_instruction <= i_instruction;
            o_valid       <= 1'b1;
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_pc          <= RST_PC;
            o_instruction <= RST_INSTR;
        end else if (enable) begin
            o_pc          <= i_pc;
            o_instruction <= i_instruction;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_dec_buf.sv
// tb/tb_fetch_dec_buf.sv - self-checking bench for fetch_dec_buf
`timescale 1ns/1ps

module tb_fetch_dec_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] i_pc;
    logic [31:0] i_instruction;
    logic [31:0] o_pc;
    logic [31:0] o_instruction;
    logic        fl_drv;
`ifdef FETCH_DEC_BUF_FLUSH_EN
    logic        i_flush;
    logic        o_valid;
    assign i_flush = fl_drv;
`endif

    int total = 0;
    int bad   = 0;

    // Reference state: what Decode must currently see.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    bit          cmp_en = 1'b0;

    always #5 clk = ~clk;

    fetch_dec_buf dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .i_pc          (i_pc),
        .i_instruction (i_instruction),
`ifdef FETCH_DEC_BUF_FLUSH_EN
        .i_flush       (i_flush),
        .o_valid       (o_valid),
`endif
        .o_pc          (o_pc),
        .o_instruction (o_instruction)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'd0;
        m_instr = 32'd0;
        m_valid = 1'b0;
    endtask

    // Apply one cycle of inputs. Glitch values are shown first and must never
    // reach the outputs; the final values are what the rising edge samples.
    task automatic cyc(input logic r, input logic en, input logic fl,
                       input logic [31:0] pc, input logic [31:0] ins, input bit glitch);
        if (glitch) begin
            enable        = $urandom_range(0, 1);
            i_pc          = $urandom;
            i_instruction = $urandom;
            #2;
        end
        rst           = r;
        enable        = en;
        fl_drv        = fl;
        i_pc          = pc;
        i_instruction = ins;
        if (!r) model_reset();
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end
`ifdef FETCH_DEC_BUF_FLUSH_EN
        else if (fl_drv) begin
            model_reset();
        end
`endif
        else if (enable === 1'b1) begin
            m_pc    = i_pc;
            m_instr = i_instruction;
            m_valid = 1'b1;
        end
        #1;
    endtask

    // Every-cycle comparison against the reference, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_pc", o_pc, m_pc);
            chk("model_instr", o_instruction, m_instr);
`ifdef FETCH_DEC_BUF_FLUSH_EN
            chk("model_valid", {31'd0, o_valid}, {31'd0, m_valid});
`endif
        end
    end

    initial begin
        rst           = 1'b0;
        enable        = 1'b1;
        fl_drv        = 1'b0;
        i_pc          = 32'd5;
        i_instruction = 32'd10;
        model_reset();
        #1;
        chk("reset_async_pc", o_pc, 32'd0);
        chk("reset_async_instr", o_instruction, 32'd0);
        cmp_en = 1'b1;

        // Held in reset with enable high and a running clock.
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 32'd5, 32'd10, 1'b0);
        cyc(1'b0, 1'bx, 1'b0, 32'd5, 32'd10, 1'b0);
        chk("reset_hold_pc", o_pc, 32'd0);
        chk("reset_hold_instr", o_instruction, 32'd0);

        // Capture with one-cycle latency, mid-cycle input change invisible.
        cyc(1'b1, 1'b1, 1'b0, 32'd5, 32'd10, 1'b0);
        chk("capture_pc", o_pc, 32'd5);
        chk("capture_instr", o_instruction, 32'd10);
        i_pc          = 32'd20;
        i_instruction = 32'd30;
        #3;
        chk("midcycle_pc", o_pc, 32'd5);
        chk("midcycle_instr", o_instruction, 32'd10);
        cyc(1'b1, 1'b1, 1'b0, 32'd20, 32'd30, 1'b0);
        chk("capture2_pc", o_pc, 32'd20);
        chk("capture2_instr", o_instruction, 32'd30);

        // Stall.
        cyc(1'b1, 1'b1, 1'b0, 32'd5, 32'd10, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'd55, 32'd67, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 32'd7, 32'd9, 1'b0);
        chk("stall_pc", o_pc, 32'd5);
        chk("stall_instr", o_instruction, 32'd10);

        // Resume.
        cyc(1'b1, 1'b1, 1'b0, 32'd99, 32'd199, 1'b0);
        chk("resume_pc", o_pc, 32'd99);
        chk("resume_instr", o_instruction, 32'd199);

        // Back-to-back.
        for (int k = 1; k <= 3; k++) begin
            cyc(1'b1, 1'b1, 1'b0, k, k * 11, 1'b0);
            chk("b2b_pc", o_pc, k);
            chk("b2b_instr", o_instruction, k * 11);
        end

        // Asynchronous reset mid-cycle.
        cyc(1'b1, 1'b1, 1'b0, 32'd99, 32'd199, 1'b0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_rst_pc", o_pc, 32'd0);
        chk("async_rst_instr", o_instruction, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'd3, 32'd4, 1'b0);
        chk("rst_edge_nocapture_pc", o_pc, 32'd0);

`ifdef FETCH_DEC_BUF_FLUSH_EN
        cyc(1'b1, 1'b1, 1'b0, 32'd99, 32'd199, 1'b0);
        chk("flush_pre_valid", {31'd0, o_valid}, 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 32'd5, 32'd6, 1'b0);
        chk("flush_pc", o_pc, 32'd0);
        chk("flush_instr", o_instruction, 32'd0);
        chk("flush_valid", {31'd0, o_valid}, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'd7, 32'd9, 1'b0);
        chk("post_flush_pc", o_pc, 32'd7);
        chk("post_flush_valid", {31'd0, o_valid}, 32'd1);
`endif

        // Randomized traffic with glitching inputs between edges.
        for (int n = 0; n < 2000; n++) begin
            logic r;
            logic en;
            r  = ($urandom_range(0, 39) != 0);
            en = $urandom_range(0, 2) != 0;
            if (!r && $urandom_range(0, 1) == 1) en = 1'bx;
            cyc(r, en, $urandom_range(0, 7) == 0, $urandom, $urandom, 1'b1);
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
